// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - buffers branch completions per mask bit and emits one resolve per cycle.
// Mispredicts win (oldest first), otherwise lowest index; mispredicts squash dependents.
module branch_resolver #(
   parameter int B_MASK_WIDTH = 4,
   parameter int NUM_BR_CMPL  = 2,
   parameter int ADDR_W       = 32
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic [NUM_BR_CMPL-1:0]               cmpl_valid,
   input  logic [NUM_BR_CMPL*B_MASK_WIDTH-1:0]  cmpl_b_m,
   input  logic [NUM_BR_CMPL*B_MASK_WIDTH-1:0]  cmpl_b_mask,
   input  logic [NUM_BR_CMPL-1:0]               cmpl_mispred,
   input  logic [NUM_BR_CMPL*ADDR_W-1:0]        cmpl_target,
   output logic [B_MASK_WIDTH-1:0]              b_mm_resolve,
   output logic                                 b_mm_mispred,
   output logic                                 restore_valid,
   output logic [ADDR_W-1:0]                    PC_restore,
   output logic [B_MASK_WIDTH-1:0]              pending_mask
);
   localparam int B = B_MASK_WIDTH;
   localparam int N = NUM_BR_CMPL;
   localparam logic [B-1:0] ONE = 1;

   logic [B-1:0]      r_valid;
   logic [B-1:0]      r_dep [B];
   logic [B-1:0]      r_misp;
   logic [ADDR_W-1:0] r_tgt [B];
   logic [B-1:0]      r_resolve;
   logic              r_mispred;
   logic [ADDR_W-1:0] r_pc;

   logic [B-1:0]      w_in_hit;
   logic [B-1:0]      w_cand_valid;
   logic [B-1:0]      w_cand_dep [B];
   logic [B-1:0]      w_cand_misp;
   logic [ADDR_W-1:0] w_cand_tgt [B];
   logic [B-1:0]      w_cand_mp;
   logic [B-1:0]      w_sel;
   logic              w_found;
   logic              w_sel_mp;
   logic [ADDR_W-1:0] w_sel_tgt;
   logic [B-1:0]      w_drop;
   logic [B-1:0]      w_survive;

   // Incoming completions bypass the buffer; lowest slot wins on a (illegal) collision.
   always_comb begin
      for (int i = 0; i < B; i++) begin
         w_in_hit[i]    = 1'b0;
         w_cand_dep[i]  = r_dep[i];
         w_cand_misp[i] = r_misp[i];
         w_cand_tgt[i]  = r_tgt[i];
         for (int k = N - 1; k >= 0; k--) begin
            if (cmpl_valid[k] && cmpl_b_m[k*B + i]) begin
               w_in_hit[i]    = 1'b1;
               w_cand_dep[i]  = cmpl_b_mask[k*B +: B];
               w_cand_misp[i] = cmpl_mispred[k];
               w_cand_tgt[i]  = cmpl_target[k*ADDR_W +: ADDR_W];
            end
         end
      end
      w_cand_valid = r_valid | w_in_hit;
      w_cand_mp    = w_cand_valid & w_cand_misp;
   end

   always_comb begin
      w_sel   = '0;
      w_found = 1'b0;
      for (int i = 0; i < B; i++) begin
         if (!w_found && w_cand_mp[i] && ((w_cand_dep[i] & w_cand_mp & ~(ONE << i)) == '0)) begin
            w_sel[i] = 1'b1;
            w_found  = 1'b1;
         end
      end
      for (int i = 0; i < B; i++) begin
         if (!w_found && w_cand_mp[i]) begin
            w_sel[i] = 1'b1;
            w_found  = 1'b1;
         end
      end
      for (int i = 0; i < B; i++) begin
         if (!w_found && w_cand_valid[i]) begin
            w_sel[i] = 1'b1;
            w_found  = 1'b1;
         end
      end
   end

   always_comb begin
      w_sel_mp  = |(w_sel & w_cand_misp);
      w_sel_tgt = '0;
      for (int i = 0; i < B; i++) begin
         if (w_sel[i]) w_sel_tgt = w_cand_tgt[i];
         w_drop[i] = w_sel_mp && ((w_cand_dep[i] & w_sel) != '0);
      end
      w_survive = w_cand_valid & ~w_sel & ~w_drop;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_valid   <= '0;
         r_misp    <= '0;
         r_resolve <= '0;
         r_mispred <= 1'b0;
         r_pc      <= '0;
         for (int i = 0; i < B; i++) begin
            r_dep[i] <= '0;
            r_tgt[i] <= '0;
         end
      end else begin
         r_valid   <= w_survive;
         r_misp    <= w_cand_misp;
         r_resolve <= w_sel;
         r_mispred <= w_sel_mp;
         r_pc      <= w_sel_mp ? w_sel_tgt : '0;
         for (int i = 0; i < B; i++) begin
            r_dep[i] <= w_cand_dep[i] & ~w_sel;
            r_tgt[i] <= w_cand_tgt[i];
         end
      end
   end

   // Protocol checks: one-hot own bit, no rewrite of a live entry, no two slots on one bit.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int k = 0; k < N; k++) begin
            if (cmpl_valid[k]) begin
               assert ($onehot(cmpl_b_m[k*B +: B]));
               assert ((cmpl_b_m[k*B +: B] & r_valid) == '0);
               for (int j = k + 1; j < N; j++) begin
                  assert (!(cmpl_valid[j] && ((cmpl_b_m[k*B +: B] & cmpl_b_m[j*B +: B]) != '0)));
               end
            end
         end
      end
   end

   assign b_mm_resolve  = r_resolve;
   assign b_mm_mispred  = r_mispred;
   assign restore_valid = r_mispred;
   assign PC_restore    = r_pc;
   assign pending_mask  = r_valid;
endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - directed self-checking bench for branch_resolver.
module tb_branch_resolver;
   logic        clock;
   logic        reset;
   logic [1:0]  cmpl_valid;
   logic [7:0]  cmpl_b_m;
   logic [7:0]  cmpl_b_mask;
   logic [1:0]  cmpl_mispred;
   logic [63:0] cmpl_target;
   logic [3:0]  b_mm_resolve;
   logic        b_mm_mispred;
   logic        restore_valid;
   logic [31:0] PC_restore;
   logic [3:0]  pending_mask;

   int checks = 0;
   int errors = 0;

   branch_resolver #(.B_MASK_WIDTH(4), .NUM_BR_CMPL(2), .ADDR_W(32)) dut (
      .clock(clock), .reset(reset),
      .cmpl_valid(cmpl_valid), .cmpl_b_m(cmpl_b_m), .cmpl_b_mask(cmpl_b_mask),
      .cmpl_mispred(cmpl_mispred), .cmpl_target(cmpl_target),
      .b_mm_resolve(b_mm_resolve), .b_mm_mispred(b_mm_mispred),
      .restore_valid(restore_valid), .PC_restore(PC_restore), .pending_mask(pending_mask)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic clr();
      cmpl_valid = '0; cmpl_b_m = '0; cmpl_b_mask = '0; cmpl_mispred = '0; cmpl_target = '0;
   endtask

   task automatic drive(input int s, input logic [3:0] bm, input logic [3:0] mask,
                        input logic mp, input logic [31:0] tgt);
      cmpl_valid[s]         = 1'b1;
      cmpl_b_m[s*4 +: 4]    = bm;
      cmpl_b_mask[s*4 +: 4] = mask;
      cmpl_mispred[s]       = mp;
      cmpl_target[s*32 +: 32] = tgt;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      checks++; if (b_mm_resolve !== 4'b0) begin errors++; $display("FAIL reset_resolve got %b exp 0000", b_mm_resolve); end
      checks++; if (b_mm_mispred !== 1'b0) begin errors++; $display("FAIL reset_mispred got %b exp 0", b_mm_mispred); end
      checks++; if (PC_restore !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", PC_restore); end
      checks++; if (pending_mask !== 4'b0) begin errors++; $display("FAIL reset_pending got %b exp 0000", pending_mask); end
   endtask

   task automatic test_single();
      drive(0, 4'b0001, 4'b0000, 1'b0, 32'h44); step(); clr();
      checks++; if (b_mm_resolve !== 4'b0001) begin errors++; $display("FAIL single_resolve got %b exp 0001", b_mm_resolve); end
      checks++; if (b_mm_mispred !== 1'b0 || restore_valid !== 1'b0) begin errors++; $display("FAIL single_mispred got %b/%b exp 0/0", b_mm_mispred, restore_valid); end
      checks++; if (PC_restore !== 32'h0) begin errors++; $display("FAIL single_pc got %h exp 0", PC_restore); end
      step();
      checks++; if (b_mm_resolve !== 4'b0 || pending_mask !== 4'b0) begin errors++; $display("FAIL single_idle got %b/%b exp 0000/0000", b_mm_resolve, pending_mask); end
   endtask

   task automatic test_two_same();
      drive(0, 4'b0010, 4'b0000, 1'b0, 32'h0); drive(1, 4'b0100, 4'b0000, 1'b0, 32'h0); step(); clr();
      checks++; if (b_mm_resolve !== 4'b0010) begin errors++; $display("FAIL two_first got %b exp 0010", b_mm_resolve); end
      checks++; if (pending_mask !== 4'b0100) begin errors++; $display("FAIL two_pending got %b exp 0100", pending_mask); end
      step();
      checks++; if (b_mm_resolve !== 4'b0100) begin errors++; $display("FAIL two_second got %b exp 0100", b_mm_resolve); end
      step();
      checks++; if (pending_mask !== 4'b0 || b_mm_resolve !== 4'b0) begin errors++; $display("FAIL two_drained got %b/%b exp 0000/0000", pending_mask, b_mm_resolve); end
   endtask

   task automatic test_mispred_priority();
      drive(0, 4'b0001, 4'b0000, 1'b0, 32'h0); drive(1, 4'b1000, 4'b0000, 1'b1, 32'h200); step(); clr();
      checks++; if (b_mm_resolve !== 4'b1000 || PC_restore !== 32'h200) begin errors++; $display("FAIL prio_setup got %b/%h exp 1000/00000200", b_mm_resolve, PC_restore); end
      checks++; if (pending_mask !== 4'b0001) begin errors++; $display("FAIL prio_buffered got %b exp 0001", pending_mask); end
      drive(0, 4'b0100, 4'b0000, 1'b1, 32'h80); step(); clr();
      checks++; if (b_mm_resolve !== 4'b0100) begin errors++; $display("FAIL prio_resolve got %b exp 0100", b_mm_resolve); end
      checks++; if (b_mm_mispred !== 1'b1 || restore_valid !== 1'b1) begin errors++; $display("FAIL prio_mispred got %b/%b exp 1/1", b_mm_mispred, restore_valid); end
      checks++; if (PC_restore !== 32'h80) begin errors++; $display("FAIL prio_pc got %h exp 00000080", PC_restore); end
      step();
      checks++; if (b_mm_resolve !== 4'b0001 || b_mm_mispred !== 1'b0 || PC_restore !== 32'h0) begin errors++; $display("FAIL prio_old got %b/%b/%h exp 0001/0/0", b_mm_resolve, b_mm_mispred, PC_restore); end
      step();
      checks++; if (b_mm_resolve !== 4'b0 || pending_mask !== 4'b0) begin errors++; $display("FAIL prio_idle got %b/%b exp 0000/0000", b_mm_resolve, pending_mask); end
   endtask

   task automatic test_dependent_squash();
      drive(0, 4'b0001, 4'b0000, 1'b0, 32'h0); drive(1, 4'b1000, 4'b0010, 1'b0, 32'h0); step(); clr();
      checks++; if (b_mm_resolve !== 4'b0001 || pending_mask !== 4'b1000) begin errors++; $display("FAIL squash_setup got %b/%b exp 0001/1000", b_mm_resolve, pending_mask); end
      drive(0, 4'b0010, 4'b0000, 1'b1, 32'h40); step(); clr();
      checks++; if (b_mm_resolve !== 4'b0010 || b_mm_mispred !== 1'b1 || PC_restore !== 32'h40) begin errors++; $display("FAIL squash_resolve got %b/%b/%h exp 0010/1/00000040", b_mm_resolve, b_mm_mispred, PC_restore); end
      checks++; if (pending_mask !== 4'b0) begin errors++; $display("FAIL squash_pending got %b exp 0000", pending_mask); end
      for (int c = 0; c < 3; c++) begin
         step();
         checks++; if (b_mm_resolve !== 4'b0) begin errors++; $display("FAIL squash_never got %b exp 0000 cycle %0d", b_mm_resolve, c); end
      end
   endtask

   task automatic test_oldest_mispred();
      drive(0, 4'b0010, 4'b0001, 1'b1, 32'h200); drive(1, 4'b0001, 4'b0000, 1'b1, 32'h100); step(); clr();
      checks++; if (b_mm_resolve !== 4'b0001 || PC_restore !== 32'h100) begin errors++; $display("FAIL oldest_resolve got %b/%h exp 0001/00000100", b_mm_resolve, PC_restore); end
      checks++; if (pending_mask !== 4'b0) begin errors++; $display("FAIL oldest_pending got %b exp 0000", pending_mask); end
      step();
      checks++; if (b_mm_resolve !== 4'b0 || b_mm_mispred !== 1'b0) begin errors++; $display("FAIL oldest_idle got %b/%b exp 0000/0", b_mm_resolve, b_mm_mispred); end
   endtask

   task automatic test_dep_strip();
      drive(0, 4'b0001, 4'b0000, 1'b0, 32'h0); drive(1, 4'b1000, 4'b0001, 1'b0, 32'h0); step(); clr();
      checks++; if (b_mm_resolve !== 4'b0001 || pending_mask !== 4'b1000) begin errors++; $display("FAIL strip_setup got %b/%b exp 0001/1000", b_mm_resolve, pending_mask); end
      drive(0, 4'b0001, 4'b0000, 1'b1, 32'h30); step(); clr();
      checks++; if (b_mm_resolve !== 4'b0001 || PC_restore !== 32'h30) begin errors++; $display("FAIL strip_mp got %b/%h exp 0001/00000030", b_mm_resolve, PC_restore); end
      checks++; if (pending_mask !== 4'b1000) begin errors++; $display("FAIL strip_survive got %b exp 1000", pending_mask); end
      step();
      checks++; if (b_mm_resolve !== 4'b1000 || b_mm_mispred !== 1'b0) begin errors++; $display("FAIL strip_final got %b/%b exp 1000/0", b_mm_resolve, b_mm_mispred); end
      step();
   endtask

   task automatic test_back_to_back();
      drive(0, 4'b1000, 4'b0000, 1'b0, 32'h0); drive(1, 4'b0100, 4'b0000, 1'b0, 32'h0); step(); clr();
      checks++; if (b_mm_resolve !== 4'b0100) begin errors++; $display("FAIL b2b_0 got %b exp 0100", b_mm_resolve); end
      drive(0, 4'b0001, 4'b0000, 1'b0, 32'h0); drive(1, 4'b0010, 4'b0000, 1'b0, 32'h0); step(); clr();
      checks++; if (b_mm_resolve !== 4'b0001 || pending_mask !== 4'b1010) begin errors++; $display("FAIL b2b_1 got %b/%b exp 0001/1010", b_mm_resolve, pending_mask); end
      step();
      checks++; if (b_mm_resolve !== 4'b0010) begin errors++; $display("FAIL b2b_2 got %b exp 0010", b_mm_resolve); end
      step();
      checks++; if (b_mm_resolve !== 4'b1000 || pending_mask !== 4'b0) begin errors++; $display("FAIL b2b_3 got %b/%b exp 1000/0000", b_mm_resolve, pending_mask); end
      step();
   endtask

   task automatic test_reset_mid();
      drive(0, 4'b1000, 4'b0000, 1'b1, 32'h50); drive(1, 4'b0001, 4'b0000, 1'b0, 32'h0); step(); clr();
      drive(0, 4'b0100, 4'b0000, 1'b1, 32'h60); drive(1, 4'b0010, 4'b0000, 1'b0, 32'h0); step(); clr();
      checks++; if (pending_mask !== 4'b0011 || b_mm_resolve !== 4'b0100) begin errors++; $display("FAIL rstmid_setup got %b/%b exp 0011/0100", pending_mask, b_mm_resolve); end
      #2 reset = 1'b1;
      #1;
      checks++; if (pending_mask !== 4'b0 || b_mm_resolve !== 4'b0 || b_mm_mispred !== 1'b0 || PC_restore !== 32'h0) begin
         errors++; $display("FAIL rstmid_clear got %b/%b/%b/%h exp 0000/0000/0/0", pending_mask, b_mm_resolve, b_mm_mispred, PC_restore);
      end
      #1 reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++; if (b_mm_resolve !== 4'b0 || pending_mask !== 4'b0) begin errors++; $display("FAIL rstmid_quiet got %b/%b exp 0000/0000 cycle %0d", b_mm_resolve, pending_mask, c); end
      end
   endtask

   initial begin
      reset = 1'b1;
      clr();
      #12;
      test_reset();
      reset = 1'b0;
      step();
      test_single();
      test_two_same();
      test_mispred_priority();
      test_dependent_squash();
      test_oldest_mispred();
      test_dep_strip();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
